// File: rtl/mirfak_wb_stage.sv
// Writeback stage: Wishbone classic load/store, load align/extend, exception select, RF write.
// Non-memory ops complete combinationally; aligned memops take 2 + wait cycles with wb_busy_o stalling upstream.
module mirfak_wb_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_pc_i,
  input  logic [31:0] wb_instruction_i,
  input  logic [31:0] wb_ex_mtval_i,
  input  logic [31:0] wb_alu_result_i,
  input  logic [31:0] wb_lsu_wdata_i,
  input  logic        wb_ex_exception_i,
  input  logic [3:0]  wb_ex_xcause_i,
  input  logic        wb_bubble_i,
  input  logic        wb_is_load_i,
  input  logic        wb_is_store_i,
  input  logic        wb_regwrite_i,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] wb_fwd_data_o,
  output logic        wb_exception_o,
  output logic [3:0]  wb_xcause_o,
  output logic [31:0] wb_mtval_o,
  output logic [31:0] wb_exc_pc_o,
  output logic        wb_retire_o,
  output logic        wb_busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state_q;
  logic        cyc_q;
  logic [31:0] ld_data_q;
  logic        fault_q;

  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] addr;
  logic        valid;
  logic        memop;
  logic        misaligned;
  logic        aligned_memop;
  logic        completion;
  logic        ex_in;
  logic        bus_fault;
  logic        exc;
  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{wb_instruction_i[31:15], wb_instruction_i[6:0]};

  assign funct3 = wb_instruction_i[14:12];
  assign rd     = wb_instruction_i[11:7];
  assign addr   = wb_alu_result_i;
  assign valid  = !wb_bubble_i && !wb_ex_exception_i;
  assign memop  = valid && (wb_is_load_i || wb_is_store_i);

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
    misaligned = misaligned && memop;
  end

  assign aligned_memop = memop && !misaligned;

  always_comb begin
    st_sel = 4'b1111;
    st_dat = wb_lsu_wdata_i;
    if (wb_is_store_i) begin
      case (funct3[1:0])
        2'b00: begin
          st_sel = 4'b0001 << addr[1:0];
          st_dat = {4{wb_lsu_wdata_i[7:0]}};
        end
        2'b01: begin
          st_sel = addr[1] ? 4'b1100 : 4'b0011;
          st_dat = {2{wb_lsu_wdata_i[15:0]}};
        end
        default: st_sel = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      dwbm_we_o   <= 1'b0;
      dwbm_sel_o  <= 4'b0000;
      dwbm_addr_o <= 32'h0;
      dwbm_dat_o  <= 32'h0;
      ld_data_q   <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (aligned_memop) begin
            dwbm_addr_o <= addr;
            dwbm_dat_o  <= st_dat;
            dwbm_sel_o  <= st_sel;
            dwbm_we_o   <= wb_is_store_i;
            cyc_q       <= 1'b1;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // err takes precedence over a simultaneous ack
          if (dwbm_ack_i || dwbm_err_i) begin
            cyc_q   <= 1'b0;
            fault_q <= dwbm_err_i;
            if (!dwbm_we_o) ld_data_q <= dwbm_dat_i;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dwbm_cyc_o = cyc_q;
  assign dwbm_stb_o = cyc_q;

  assign ld_byte = ld_data_q[{addr[1:0], 3'b000} +: 8];
  assign ld_half = addr[1] ? ld_data_q[31:16] : ld_data_q[15:0];

  always_comb begin
    case (funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = ld_data_q;
    endcase
  end

  assign completion = ((state_q == S_IDLE) && !aligned_memop) || (state_q == S_DONE);
  assign ex_in      = wb_ex_exception_i && !wb_bubble_i;
  assign bus_fault  = (state_q == S_DONE) && fault_q;
  assign exc        = completion && (ex_in || misaligned || bus_fault);

  always_comb begin
    wb_xcause_o = 4'd0;
    wb_mtval_o  = 32'h0;
    if (exc) begin
      if (ex_in) begin
        wb_xcause_o = wb_ex_xcause_i;
        wb_mtval_o  = wb_ex_mtval_i;
      end else if (misaligned) begin
        wb_xcause_o = wb_is_load_i ? 4'd4 : 4'd6;
        wb_mtval_o  = addr;
      end else begin
        wb_xcause_o = wb_is_load_i ? 4'd5 : 4'd7;
        wb_mtval_o  = addr;
      end
    end
  end

  assign wb_exception_o = exc;
  assign wb_exc_pc_o    = wb_pc_i;
  assign rf_we_o        = completion && valid && wb_regwrite_i && (rd != 5'd0) && !exc;
  assign rf_waddr_o     = rd;
  assign rf_wdata_o     = wb_is_load_i ? ld_ext : wb_alu_result_i;
  assign wb_fwd_data_o  = rf_wdata_o;
  assign wb_retire_o    = completion && !wb_bubble_i && !exc;
  assign wb_busy_o      = ((state_q == S_IDLE) && aligned_memop) || (state_q == S_ACCESS);

endmodule

// File: tb/tb_mirfak_wb_stage.sv
// Randomized + directed bench for mirfak_wb_stage against a transaction-level reference model.
module tb_mirfak_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr, mtv, alu, wdat;
  logic        exc_in, bub, ld, st, rw;
  logic [3:0]  xc;
  logic [31:0] b_addr, b_dato, b_dati;
  logic [3:0]  b_sel;
  logic        b_cyc, b_stb, b_we, b_ack, b_err;
  logic        rf_we, exc_o, retire, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fwd, mtval_o, exc_pc;
  logic [3:0]  xcause_o;

  always #5 clk = ~clk;

  mirfak_wb_stage dut (
    .clk_i(clk), .rst_i(rst),
    .wb_pc_i(pc), .wb_instruction_i(instr), .wb_ex_mtval_i(mtv),
    .wb_alu_result_i(alu), .wb_lsu_wdata_i(wdat),
    .wb_ex_exception_i(exc_in), .wb_ex_xcause_i(xc), .wb_bubble_i(bub),
    .wb_is_load_i(ld), .wb_is_store_i(st), .wb_regwrite_i(rw),
    .dwbm_addr_o(b_addr), .dwbm_dat_o(b_dato), .dwbm_sel_o(b_sel),
    .dwbm_cyc_o(b_cyc), .dwbm_stb_o(b_stb), .dwbm_we_o(b_we),
    .dwbm_dat_i(b_dati), .dwbm_ack_i(b_ack), .dwbm_err_i(b_err),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .wb_fwd_data_o(fwd), .wb_exception_o(exc_o), .wb_xcause_o(xcause_o),
    .wb_mtval_o(mtval_o), .wb_exc_pc_o(exc_pc), .wb_retire_o(retire),
    .wb_busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected values for the current cycle, set by the driver before each negedge
  logic        cmp_en = 1'b0;
  logic        e_busy = 0, e_cyc = 0, e_chk_dat = 0, e_we = 0, e_rf_we = 0, e_exc = 0, e_ret = 0, e_done = 0;
  logic [31:0] e_addr = 0, e_dat = 0, e_wdata = 0, e_mtval = 0;
  logic [3:0]  e_sel = 0, e_cause = 0;
  logic [4:0]  e_waddr = 0;

  // observations recorded for the literal pins
  int          o_cyc_cnt, o_busy_cnt;
  logic [3:0]  o_sel, o_cause;
  logic [31:0] o_dat, o_wdata, o_mtval;
  logic        o_we, o_rf_we, o_exc, o_ret;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, e_busy);
      chk("cyc", b_cyc, e_cyc);
      chk("stb", b_stb, e_cyc);
      if (e_cyc) begin
        chk("bus_addr", b_addr, e_addr);
        chk("bus_sel", b_sel, e_sel);
        chk("bus_we", b_we, e_we);
        if (e_chk_dat) chk("bus_dat", b_dato, e_dat);
      end
      chk("rf_we", rf_we, e_rf_we);
      if (e_rf_we) begin
        chk("rf_waddr", rf_waddr, e_waddr);
        chk("rf_wdata", rf_wdata, e_wdata);
        chk("fwd", fwd, e_wdata);
      end
      chk("exception", exc_o, e_exc);
      if (e_exc) begin
        chk("xcause", xcause_o, e_cause);
        chk("mtval", mtval_o, e_mtval);
      end
      chk("exc_pc", exc_pc, pc);
      chk("retire", retire, e_ret);
      if (b_cyc) begin o_cyc_cnt++; o_sel = b_sel; o_dat = b_dato; o_we = b_we; end
      if (busy) o_busy_cnt++;
      if (e_done) begin
        o_rf_we = rf_we; o_wdata = rf_wdata; o_exc = exc_o;
        o_cause = xcause_o; o_mtval = mtval_o; o_ret = retire;
      end
    end
  end

  // Wishbone slave: answers after sl_wait extra cycles; resp 0..3 ack, 4 err, 5 ack+err
  logic        sl_en = 1'b1;
  int          sl_wait = 0, sl_resp = 0, sl_cnt = 0;
  logic [31:0] sl_data = 0;

  always @(negedge clk) begin
    #1;
    if (sl_en) begin
      if (!rst && b_cyc && b_stb) begin
        sl_cnt++;
        if (sl_cnt == sl_wait + 1) begin
          b_ack  = (sl_resp != 4);
          b_err  = (sl_resp >= 4);
          b_dati = sl_data;
        end else begin
          b_ack  = 1'b0;
          b_err  = 1'b0;
          b_dati = $urandom;
        end
      end else begin
        sl_cnt = 0;
        b_ack  = 1'b0;
        b_err  = 1'b0;
      end
    end
  end

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    longint v;
    logic [31:0] sh;
    sh = d >> (8 * a[1:0]);
    case (f3)
      3'd0: begin v = sh % 256;   if (v >= 128)   v -= 256;   end
      3'd1: begin v = sh % 65536; if (v >= 32768) v -= 65536; end
      3'd4: v = sh % 256;
      3'd5: v = sh % 65536;
      default: v = d;
    endcase
    return v[31:0];
  endfunction

  // Applies one EX/WB entry, predicts every cycle until it completes, then leaves the bench at posedge+1.
  task automatic txn(input logic [31:0] t_pc, t_instr, t_alu, t_wdat, input logic t_exc,
                     input logic [3:0] t_xc, input logic [31:0] t_mtv,
                     input logic t_bub, t_ld, t_st, t_rw, input int w, input int resp, input logic [31:0] rdat);
    logic [2:0] f3;
    logic [4:0] rdn;
    int sz, ncyc;
    logic valid, memop, mis, aligned, fault, x;
    pc = t_pc; instr = t_instr; alu = t_alu; wdat = t_wdat; exc_in = t_exc; xc = t_xc;
    mtv = t_mtv; bub = t_bub; ld = t_ld; st = t_st; rw = t_rw;
    sl_wait = w; sl_resp = resp; sl_data = rdat;
    o_cyc_cnt = 0; o_busy_cnt = 0;
    f3 = t_instr[14:12];
    rdn = t_instr[11:7];
    sz = 1 << f3[1:0];
    if (sz > 4) sz = 4;
    valid = !t_bub && !t_exc;
    memop = valid && (t_ld || t_st);
    mis = memop && ((t_alu % sz) != 0);
    aligned = memop && !mis;
    fault = aligned && (resp >= 4);
    x = (t_exc && !t_bub) || mis || fault;
    ncyc = aligned ? w + 3 : 1;
    e_addr = t_alu;
    e_we = t_st;
    e_chk_dat = t_st;
    e_sel = t_st ? 4'(((1 << sz) - 1) << t_alu[1:0]) : 4'hF;
    e_dat = (sz == 1) ? (t_wdat % 256) * 32'h01010101 :
            (sz == 2) ? (t_wdat % 65536) * 32'h00010001 : t_wdat;
    e_waddr = rdn;
    e_wdata = t_ld ? m_load(f3, t_alu, rdat) : t_alu;
    e_cause = (t_exc && !t_bub) ? t_xc : mis ? (t_ld ? 4'd4 : 4'd6) : (t_ld ? 4'd5 : 4'd7);
    e_mtval = (t_exc && !t_bub) ? t_mtv : t_alu;
    for (int k = 0; k < ncyc; k++) begin
      e_done  = (k == ncyc - 1);
      e_busy  = aligned && !e_done;
      e_cyc   = aligned && k >= 1 && k <= w + 1;
      e_rf_we = e_done && valid && t_rw && rdn != 0 && !x;
      e_exc   = e_done && x;
      e_ret   = e_done && !t_bub && !x;
      @(posedge clk); #1;
    end
    e_done = 0;
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rdn, input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3; r[11:7] = rdn; r[6:0] = opc;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    {pc, instr, mtv, alu, wdat} = '0;
    {exc_in, ld, st, rw} = '0;
    bub = 1'b1; xc = 0;
    b_ack = 0; b_err = 0; b_dati = 0;
    #12;
    chk("rst_cyc", b_cyc, 0); chk("rst_stb", b_stb, 0); chk("rst_we", b_we, 0);
    chk("rst_sel", b_sel, 0); chk("rst_addr", b_addr, 0); chk("rst_dat", b_dato, 0);
    chk("rst_busy", busy, 0); chk("rst_rf_we", rf_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    // ADD
    txn(32'h100, mk_instr(3'd0, 5'd5, 7'h33), 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("add_we", o_rf_we, 1); chk("add_wdata", o_wdata, 32'h12345678); chk("add_ret", o_ret, 1);
    // LB 0x1003, two wait cycles
    txn(32'h104, mk_instr(3'd0, 5'd6, 7'h03), 32'h1003, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 32'h80FFFFFF);
    chk("lb_cyc_cycles", o_cyc_cnt, 3); chk("lb_busy_cycles", o_busy_cnt, 4);
    chk("lb_wdata", o_wdata, 32'hFFFFFF80);
    // LHU 0x2002
    txn(32'h108, mk_instr(3'd5, 5'd7, 7'h03), 32'h2002, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'hBEEF0000);
    chk("lhu_wdata", o_wdata, 32'h0000BEEF);
    // SH 0x2002
    txn(32'h10C, mk_instr(3'd1, 5'd0, 7'h23), 32'h2002, 32'h0000ABCD, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    chk("sh_sel", o_sel, 4'b1100); chk("sh_dat", o_dat, 32'hABCDABCD); chk("sh_we", o_we, 1);
    chk("sh_rf_we", o_rf_we, 0);
    // misaligned LW / SW
    txn(32'h110, mk_instr(3'd2, 5'd8, 7'h03), 32'h1001, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("lw_mis_cyc", o_cyc_cnt, 0); chk("lw_mis_exc", o_exc, 1); chk("lw_mis_cause", o_cause, 4);
    chk("lw_mis_mtval", o_mtval, 32'h1001); chk("lw_mis_ret", o_ret, 0);
    txn(32'h114, mk_instr(3'd2, 5'd0, 7'h23), 32'h1002, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("sw_mis_cause", o_cause, 6);
    // bus errors
    txn(32'h118, mk_instr(3'd2, 5'd0, 7'h23), 32'h3000, 32'h55, 0, 0, 0, 0, 0, 1, 0, 1, 4, 0);
    chk("sw_err_cause", o_cause, 7); chk("sw_err_mtval", o_mtval, 32'h3000); chk("sw_err_ret", o_ret, 0);
    txn(32'h11C, mk_instr(3'd2, 5'd0, 7'h23), 32'h3004, 32'h66, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
    chk("sw_both_cause", o_cause, 7);
    // bubble load and rd=0 load
    txn(32'h120, mk_instr(3'd2, 5'd9, 7'h03), 32'h4000, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 32'h1);
    chk("bubble_we", o_rf_we, 0); chk("bubble_ret", o_ret, 0);
    txn(32'h124, mk_instr(3'd2, 5'd0, 7'h03), 32'h4000, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h2);
    chk("rd0_we", o_rf_we, 0);

    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[31:4] = 0;
      if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      txn($urandom, mk_instr(f3, 5'($urandom), kind == 1 ? 7'h03 : kind == 2 ? 7'h23 : 7'h13),
          a, $urandom, ($urandom_range(0, 9) == 0), 4'($urandom), $urandom,
          ($urandom_range(0, 7) == 0), kind == 1, kind == 2,
          (kind != 2) || ($urandom_range(0, 3) == 0),
          $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
    end

    // reset in the middle of a bus access
    cmp_en = 1'b0;
    sl_en = 1'b0;
    b_ack = 0; b_err = 0;
    pc = 32'h200; instr = mk_instr(3'd2, 5'd0, 7'h23); alu = 32'h5000; wdat = 32'h77;
    bub = 0; exc_in = 0; ld = 0; st = 1; rw = 0;
    @(posedge clk); #1;
    chk("pre_rst_cyc", b_cyc, 1);
    #2;
    rst = 1'b1; bub = 1'b1;
    #1;
    chk("mid_rst_cyc", b_cyc, 0); chk("mid_rst_stb", b_stb, 0); chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    b_ack = 1'b1;
    instr = mk_instr(3'd0, 5'd7, 7'h33); alu = 32'hCAFE0001; bub = 0; st = 0; rw = 1;
    #1;
    chk("post_rst_rf_we", rf_we, 1); chk("post_rst_wdata", rf_wdata, 32'hCAFE0001);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;
    chk("late_ack_cyc", b_cyc, 0); chk("late_ack_busy", busy, 0); chk("late_ack_rf_we", rf_we, 1);
    b_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
